// File: rtl/tetris_pkg.sv
// Shared types and sizes for the playfield map, block position and display reader.
package tetris_pkg;

    localparam int unsigned ROWS      = 20;
    localparam int unsigned COLS      = 10;
    localparam int unsigned CELL_BITS = 4;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned COL_W     = 4;
    localparam int unsigned DIFF_W    = 11;

    typedef logic [ROWS-1:0][COLS-1:0][CELL_BITS-1:0] pixmap_t;
    typedef logic [COLS-1:0][CELL_BITS-1:0]           pixrow_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
    } shape_pos_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        SWAP = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pixmap_bank_pair.sv
// Front/back map and block-position banks: row writes land in the back bank,
// cell reads come from the front bank, and swap flips which is which.
module pixmap_bank_pair
    import tetris_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 row_we,
    input  logic [ROW_W-1:0]     row_idx,
    input  pixrow_t              row_data,
    input  logic                 shape_we,
    input  shape_pos_t           shape_data,
    input  logic                 swap,
    input  logic [ROW_W-1:0]     rd_row,
    input  logic [COL_W-1:0]     rd_col,
    output logic [CELL_BITS-1:0] rd_cell_c,
    output shape_pos_t           front_shape_c
);

    pixmap_t    map_q   [2];
    shape_pos_t shape_q [2];
    logic       front_q;
    logic       back;
    logic       shape_sel;

    assign back = ~front_q;
    // Shape writes target whichever bank is the back bank after a same-cycle swap.
    assign shape_sel = ~(front_q ^ swap);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            map_q[0]   <= '0;
            map_q[1]   <= '0;
            shape_q[0] <= '0;
            shape_q[1] <= '0;
            front_q    <= 1'b0;
        end else begin
            if (row_we) begin
                map_q[back][row_idx] <= row_data;
            end
            if (shape_we) begin
                shape_q[shape_sel] <= shape_data;
            end
            if (swap) begin
                front_q <= ~front_q;
            end
        end
    end

    assign rd_cell_c     = map_q[front_q][rd_row][rd_col];
    assign front_shape_c = shape_q[front_q];

endmodule

// File: rtl/playfield_reader.sv
// Double-buffered playfield reader: snapshots the live map each frame and answers
// per-pixel board/shape/colour queries through a 2-stage pipeline.
module playfield_reader
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_X0  = 240,
    parameter int unsigned BOARD_Y0  = 80,
    parameter int unsigned CELL_LOG2 = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  pixmap_t              PixelMapIn,
    input  logic [COORD_W-1:0]   shape_x,
    input  logic [COORD_W-1:0]   shape_y,
    input  logic [COORD_W-1:0]   shape_size_x,
    input  logic [COORD_W-1:0]   shape_size_y,
    input  logic                 pix_valid,
    input  logic [COORD_W-1:0]   DrawX,
    input  logic [COORD_W-1:0]   DrawY,
    output logic                 out_valid,
    output logic [CELL_BITS-1:0] color_idx,
    output logic                 in_board,
    output logic                 in_shape,
    output logic                 copy_busy
);

    rd_state_e          state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               row_we_c;
    logic               shape_we_c;
    logic               swap_c;
    shape_pos_t         live_shape_c;
    shape_pos_t         front_shape_c;
    logic [CELL_BITS-1:0] rd_cell_c;

    logic               v1_q;
    logic [ROW_W-1:0]   row1_q;
    logic [COL_W-1:0]   col1_q;
    logic               board1_q;
    logic               shape1_q;

    logic [DIFF_W-1:0]  rx_c, ry_c;
    logic [DIFF_W-1:0]  col_full_c, row_full_c;
    logic [DIFF_W-1:0]  x_end_c, y_end_c;
    logic               in_board_c, in_shape_c;

    assign live_shape_c = '{x: shape_x, y: shape_y, sx: shape_size_x, sy: shape_size_y};

    pixmap_bank_pair u_banks (
        .clk          (Clk),
        .rst_n        (Reset),
        .row_we       (row_we_c),
        .row_idx      (row_q),
        .row_data     (PixelMapIn[row_q]),
        .shape_we     (shape_we_c),
        .shape_data   (live_shape_c),
        .swap         (swap_c),
        .rd_row       (row1_q),
        .rd_col       (col1_q),
        .rd_cell_c    (rd_cell_c),
        .front_shape_c(front_shape_c)
    );

    // Copy FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            copy_busy <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            copy_busy <= (state_d != IDLE);
        end
    end

    // Next state: a frame_start in any state (re)starts the copy at row 0.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        row_we_c   = 1'b0;
        shape_we_c = 1'b0;
        swap_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    shape_we_c = 1'b1;
                    row_d      = '0;
                    state_d    = COPY;
                end
            end
            COPY: begin
                if (frame_start) begin
                    shape_we_c = 1'b1;
                    row_d      = '0;
                end else begin
                    row_we_c = 1'b1;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = SWAP;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            SWAP: begin
                swap_c = 1'b1;
                if (frame_start) begin
                    shape_we_c = 1'b1;
                    row_d      = '0;
                    state_d    = COPY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage-1 arithmetic; bit 10 of each difference is its sign.
    always_comb begin
        rx_c       = DIFF_W'(DrawX) - DIFF_W'(BOARD_X0);
        ry_c       = DIFF_W'(DrawY) - DIFF_W'(BOARD_Y0);
        col_full_c = rx_c >> CELL_LOG2;
        row_full_c = ry_c >> CELL_LOG2;
        in_board_c = !rx_c[DIFF_W-1] && !ry_c[DIFF_W-1]
                     && (col_full_c < DIFF_W'(COLS)) && (row_full_c < DIFF_W'(ROWS));
        x_end_c    = DIFF_W'(front_shape_c.x) + DIFF_W'(front_shape_c.sx);
        y_end_c    = DIFF_W'(front_shape_c.y) + DIFF_W'(front_shape_c.sy);
        in_shape_c = (DIFF_W'(DrawX) >= DIFF_W'(front_shape_c.x)) && (DIFF_W'(DrawX) < x_end_c)
                     && (DIFF_W'(DrawY) >= DIFF_W'(front_shape_c.y)) && (DIFF_W'(DrawY) < y_end_c);
    end

    // Query pipeline: stage 1 decodes the pixel, stage 2 reads the front bank.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            v1_q      <= 1'b0;
            row1_q    <= '0;
            col1_q    <= '0;
            board1_q  <= 1'b0;
            shape1_q  <= 1'b0;
            out_valid <= 1'b0;
            color_idx <= '0;
            in_board  <= 1'b0;
            in_shape  <= 1'b0;
        end else begin
            v1_q      <= pix_valid;
            row1_q    <= ROW_W'(row_full_c);
            col1_q    <= COL_W'(col_full_c);
            board1_q  <= in_board_c;
            shape1_q  <= in_shape_c;
            out_valid <= v1_q;
            color_idx <= board1_q ? rd_cell_c : '0;
            in_board  <= board1_q;
            in_shape  <= shape1_q;
        end
    end

endmodule

// File: tb/tb_playfield_reader.sv
// Scoreboard bench for playfield_reader: queries push expected results, a
// negedge monitor pops and compares whenever out_valid is presented.
module tb_playfield_reader;
    import tetris_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        frame_start;
    pixmap_t     PixelMapIn;
    logic [9:0]  shape_x, shape_y, shape_size_x, shape_size_y;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic        out_valid;
    logic [3:0]  color_idx;
    logic        in_board, in_shape, copy_busy;

    typedef struct {
        logic [3:0] c;
        logic       b;
        logic       s;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    logic chk_busy = 1'b0;
    logic exp_busy = 1'b0;
    logic chk_rst = 1'b0;
    logic fin = 1'b0;
    logic fin_done = 1'b0;

    playfield_reader dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .PixelMapIn  (PixelMapIn),
        .shape_x     (shape_x),
        .shape_y     (shape_y),
        .shape_size_x(shape_size_x),
        .shape_size_y(shape_size_y),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .out_valid   (out_valid),
        .color_idx   (color_idx),
        .in_board    (in_board),
        .in_shape    (in_shape),
        .copy_busy   (copy_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the only place comparisons are made.
    always @(negedge Clk) begin
        exp_t e;
        if (chk_busy) chk("copy_busy", int'(copy_busy), int'(exp_busy));
        if (chk_rst) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_color_idx", int'(color_idx), 0);
            chk("rst_in_board",  int'(in_board), 0);
            chk("rst_in_shape",  int'(in_shape), 0);
            chk("rst_copy_busy", int'(copy_busy), 0);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("out_valid_unexpected", int'(out_valid), 0);
            end else begin
                e = q.pop_front();
                chk("latency",   cyc, e.cyc);
                chk("color_idx", int'(color_idx), int'(e.c));
                chk("in_board",  int'(in_board), int'(e.b));
                chk("in_shape",  int'(in_shape), int'(e.s));
            end
        end
        if (fin && !fin_done) begin
            chk("pending_queries", q.size(), 0);
            fin_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic query(input logic [9:0] x, input logic [9:0] y,
                         input logic [3:0] c, input logic b, input logic s);
        exp_t e;
        DrawX     = x;
        DrawY     = y;
        pix_valid = 1'b1;
        e.c = c; e.b = b; e.s = s; e.cyc = cyc + 2;
        q.push_back(e);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic busy(input logic b);
        exp_busy = b;
        chk_busy = 1'b1;
        @(negedge Clk);
        #1 chk_busy = 1'b0;
    endtask

    task automatic rst_check();
        chk_rst = 1'b1;
        @(negedge Clk);
        #1 chk_rst = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_shape(input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] sx, input logic [9:0] sy);
        shape_x = x; shape_y = y; shape_size_x = sx; shape_size_y = sy;
    endtask

    initial begin
        Reset = 1'b0; frame_start = 1'b0; PixelMapIn = '0;
        set_shape(10'd0, 10'd0, 10'd0, 10'd0);
        pix_valid = 1'b0; DrawX = '0; DrawY = '0;
        repeat (3) tick();
        rst_check();
        Reset = 1'b1;
        tick();
        busy(1'b0);

        // Empty board after reset.
        query(10'd240, 10'd80,  4'h0, 1'b1, 1'b0);
        query(10'd300, 10'd200, 4'h0, 1'b1, 1'b0);
        query(10'd399, 10'd399, 4'h0, 1'b1, 1'b0);
        repeat (3) tick();

        // First full copy; swap lands 22 cycles after the pulse.
        PixelMapIn[19][0] = 4'h5;
        PixelMapIn[19][9] = 4'hA;
        PixelMapIn[2][4]  = 4'h3;
        set_shape(10'd288, 10'd96, 10'd32, 10'd32);
        pulse();
        busy(1'b1);
        repeat (19) tick();
        query(10'd240, 10'd384, 4'h0, 1'b1, 1'b0);
        busy(1'b1);
        query(10'd240, 10'd384, 4'h5, 1'b1, 1'b0);
        busy(1'b0);
        query(10'd240, 10'd384, 4'h5, 1'b1, 1'b0);
        query(10'd239, 10'd80,  4'h0, 1'b0, 1'b0);
        query(10'd400, 10'd80,  4'h0, 1'b0, 1'b0);
        query(10'd399, 10'd399, 4'hA, 1'b1, 1'b0);
        query(10'd319, 10'd127, 4'h3, 1'b1, 1'b1);
        query(10'd320, 10'd127, 4'h0, 1'b1, 1'b0);
        query(10'd288, 10'd96,  4'h0, 1'b1, 1'b1);
        query(10'd287, 10'd96,  4'h0, 1'b1, 1'b0);
        repeat (3) tick();

        // Abort mid-copy: second pulse at row 10 restarts with relatched shape.
        PixelMapIn[19][0] = 4'h7;
        set_shape(10'd0, 10'd0, 10'd16, 10'd16);
        pulse();
        busy(1'b1);
        repeat (9) tick();
        set_shape(10'd320, 10'd112, 10'd16, 10'd16);
        pulse();
        busy(1'b1);
        repeat (10) tick();
        query(10'd240, 10'd384, 4'h5, 1'b1, 1'b0);
        query(10'd300, 10'd100, 4'h0, 1'b1, 1'b1);
        repeat (7) tick();
        query(10'd240, 10'd384, 4'h5, 1'b1, 1'b0);
        busy(1'b1);
        query(10'd240, 10'd384, 4'h7, 1'b1, 1'b0);
        busy(1'b0);
        query(10'd320, 10'd112, 4'h0, 1'b1, 1'b1);
        query(10'd300, 10'd100, 4'h0, 1'b1, 1'b0);
        repeat (3) tick();

        // Reset during a copy clears banks and outputs.
        pulse();
        repeat (5) tick();
        Reset = 1'b0;
        tick();
        rst_check();
        Reset = 1'b1;
        tick();
        query(10'd240, 10'd384, 4'h0, 1'b1, 1'b0);
        query(10'd320, 10'd112, 4'h0, 1'b1, 1'b0);
        busy(1'b0);
        repeat (4) tick();

        fin = 1'b1;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/playfield_reader.md
# playfield_reader

Display-side reader for the game's 20×10×4 pixel map and falling-block position, which the datapath writes. On each frame start it copies the live map and block position into a back bank one row per cycle, then swaps banks so the VGA scan never sees a half-updated board. It answers per-pixel `DrawX`/`DrawY` queries through a 2-stage pipeline, returning the cell colour index plus board and shape membership flags to the colour mapper.

## Interface
Parameters:
- `BOARD_X0`, default 240: left edge of board, screen pixels
- `BOARD_Y0`, default 80: top edge of board, screen pixels
- `CELL_LOG2`, default 4: cell size is 2^CELL_LOG2 pixels (16)

Ports:
- `Clk`  in  1  system clock
- `Reset`  in  1  synchronous, active-low
- `frame_start`  in  1  one-cycle pulse at start of vertical blank
- `PixelMapIn`  in  [19:0][9:0][3:0]  live map from datapath; row 0 is the top row
- `shape_x`, `shape_y`  in  10 each  live block top-left, screen pixels
- `shape_size_x`, `shape_size_y`  in  10 each  live block extent, pixels
- `pix_valid`  in  1  `DrawX`/`DrawY` valid this cycle
- `DrawX`, `DrawY`  in  10 each  pixel being scanned
- `out_valid`  out  1  result valid
- `color_idx`  out  4  cell value; 0 when outside the board
- `in_board`  out  1  pixel lies inside the 10×20 cell area
- `in_shape`  out  1  pixel lies inside the latched block rectangle
- `copy_busy`  out  1  back-bank copy in progress

## Operation
- Two banks, front and back. Each bank holds a 20×10×4 map plus latched `shape_x`, `shape_y`, `shape_size_x` and `shape_size_y`. Queries read only the front bank.
- The FSM has three states: IDLE, COPY and SWAP.
  - IDLE: on `frame_start`, latch all four shape inputs into the back bank, set row=0 and go to COPY.
  - COPY: copy `PixelMapIn[row]` into back bank row `row`, then increment `row`. After row 19, go to SWAP.
  - SWAP: toggle the front/back select, then go to IDLE. The new front bank is visible to queries from the next cycle.
- A `frame_start` during COPY aborts the copy: no swap occurs, shape inputs are relatched, and row restarts at 0. A `frame_start` during SWAP is honoured after the swap, as if it had arrived in IDLE.
- Rows copied in different cycles may come from different datapath updates. This is accepted; the datapath does not change during vertical blank.
- `copy_busy` is 1 in COPY and SWAP.
- Query arithmetic uses 11-bit signed differences: rx = `DrawX` − `BOARD_X0`, ry = `DrawY` − `BOARD_Y0`.
  - col = rx >> `CELL_LOG2`, row = ry >> `CELL_LOG2`.
  - `in_board` = (rx ≥ 0) && (ry ≥ 0) && (col < 10) && (row < 20).
  - `in_shape` = `shape_x` ≤ `DrawX` < `shape_x` + `shape_size_x`, and likewise for y. Sums are computed 11 bits wide, with no wrap.
  - `color_idx` = front[row][col] when `in_board`, else 0.

## Timing
- Reset (`Reset`=0 at a `Clk` edge): both banks cleared to 0, front select = 0, state IDLE, row = 0, and all outputs 0.
- Query latency is 2 cycles. `pix_valid` at cycle t produces `out_valid` and results at t+2. One query is accepted per cycle with no stall.
- Stage 1 registers col, row, `in_board` and `in_shape`. Stage 2 registers the bank read.
- A bank swap at cycle s affects queries whose stage 2 occurs at s+1 or later.
- A full copy takes 22 cycles from `frame_start` to the new front bank being visible: 1 cycle to latch, 20 cycles of COPY, 1 cycle of SWAP.
- Queries are never blocked by copying, because the front bank is never written.

## Structure
- `tetris_pkg` holds:
  - `ROWS`=20, `COLS`=10, `CELL_BITS`=4
  - typedef `pixmap_t` = logic [ROWS-1:0][COLS-1:0][CELL_BITS-1:0]
  - typedef `shape_pos_t` (x, y, sx, sy)
  - enum `rd_state_e` {IDLE, COPY, SWAP}
- Sub-module `pixmap_bank_pair`: two banks with a row write port to the back bank, a cell read port from the front bank, and swap control. The FSM and query pipeline remain in `playfield_reader`.

## Test plan
- Reset, then 3 queries inside the board → `color_idx`=0, `in_board`=1, `out_valid` 2 cycles after each `pix_valid`.
- Map row 19 col 0 = 4'h5, pulse `frame_start`, wait 22 cycles, query (240, 384) → `color_idx`=5 at t+2. The same query issued before the swap → 0.
- Query (239, 80) and (400, 80) → `in_board`=0, `color_idx`=0. Query (399, 399) → `in_board`=1 at row 19, col 9.
- Shape latched at (288, 96) with size 32×32, query (319, 127) → `in_shape`=1. Query (320, 127) → `in_shape`=0.
- `frame_start` at COPY row 10 → `copy_busy` stays 1, with no swap until 22 cycles after the second pulse. The front bank is unchanged meanwhile.
- Assert `Reset` low during COPY → next cycle IDLE, banks 0, outputs 0.
